melody_seq: RTL

MELODY_SEQ -- requirements
Module: melody_seq

---
 rtl/melody_seq.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/melody_seq.sv
// melody_seq -- plays a fixed 16-entry song by driving a downstream tone stage.
//
// Each song entry is a 3-bit note code (0 = rest, 1..7 = DO..XI) and a 2-bit
// beats field (field b means b+1 beats).  Every entry plays as a NOTE that lasts
// beats*(TIME_UNIT+1) cycles, followed by a silent GAP of GAP_TIME+1 cycles.
// Playback can be paused/resumed with key_play and aborted with key_stop.
//
// Ports:
//   sys_clk       in   system clock
//   sys_rst_n     in   synchronous active-low reset
//   key_play      in   single-cycle pulse: start (IDLE), pause (NOTE/GAP), resume (PAUSE)
//   key_stop      in   single-cycle pulse: abort to IDLE; has priority over key_play
//   loop_en       in   level, sampled at the end of the last entry's gap: 1 = restart song
//   freq_cnt_max  out  divider count for the tone stage, 0 when silent
//   beep_en       out  1 = tone stage drives the buzzer
//   note_idx      out  song table index being played
//   playing       out  1 while in NOTE or GAP
//   song_done     out  one-cycle pulse when a non-looped song finishes
//
// All outputs are registered and reflect the state entered at the same edge,
// so an input pulse shows up on the outputs in the following cycle.
module melody_seq #(
  parameter logic [24:0] TIME_UNIT = 25'd12_499_999,
  parameter logic [24:0] GAP_TIME  = 25'd2_499_999,
  parameter logic [17:0] DO        = 18'd190839,
  parameter logic [17:0] RE        = 18'd170067,
  parameter logic [17:0] MI        = 18'd151514,
  parameter logic [17:0] FA        = 18'd143266,
  parameter logic [17:0] SO        = 18'd127551,
  parameter logic [17:0] LA        = 18'd113636,
  parameter logic [17:0] XI        = 18'd101214
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_play,
  input  logic        key_stop,
  input  logic        loop_en,
  output logic [17:0] freq_cnt_max,
  output logic        beep_en,
  output logic [3:0]  note_idx,
  output logic        playing,
  output logic        song_done
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP, PAUSE} state_t;

  // Song table, note code part.
  function automatic logic [2:0] song_code(input logic [3:0] idx);
    logic [2:0] c;
    case (idx)
      4'd0, 4'd1:         c = 3'd1;
      4'd2, 4'd3:         c = 3'd5;
      4'd4, 4'd5:         c = 3'd6;
      4'd6:               c = 3'd5;
      4'd7, 4'd8:         c = 3'd4;
      4'd9, 4'd10:        c = 3'd3;
      4'd11, 4'd12:       c = 3'd2;
      4'd13:              c = 3'd1;
      default:            c = 3'd0;  // 14, 15 are rests
    endcase
    return c;
  endfunction

  // Song table, beats field (beats minus one): only idx 6 and 13 are two beats.
  function automatic logic [1:0] song_beats(input logic [3:0] idx);
    return (idx == 4'd6 || idx == 4'd13) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [17:0] divider(input logic [2:0] code);
    logic [17:0] d;
    case (code)
      3'd1:    d = DO;
      3'd2:    d = RE;
      3'd3:    d = MI;
      3'd4:    d = FA;
      3'd5:    d = SO;
      3'd6:    d = LA;
      3'd7:    d = XI;
      default: d = 18'd0;
    endcase
    return d;
  endfunction

  state_t      state_reg, state_next;
  state_t      resume_reg, resume_next;
  logic [3:0]  idx_reg, idx_next;
  logic [24:0] cyc_reg, cyc_next;
  logic [1:0]  beat_reg, beat_next;
  logic        done_next;

  // Result of letting NOTE/GAP run for one more cycle.
  state_t      adv_state;
  logic [3:0]  adv_idx;
  logic [24:0] adv_cyc;
  logic [1:0]  adv_beat;
  logic        adv_done;

  logic [2:0]  code_next;
  logic [17:0] freq_next;

  always_comb begin
    adv_state = state_reg;
    adv_idx   = idx_reg;
    adv_cyc   = cyc_reg;
    adv_beat  = beat_reg;
    adv_done  = 1'b0;
    case (state_reg)
      NOTE: begin
        if (cyc_reg == TIME_UNIT) begin
          adv_cyc = 25'd0;
          if (beat_reg == song_beats(idx_reg)) begin
            adv_state = GAP;
            adv_beat  = 2'd0;
          end else begin
            adv_beat = beat_reg + 2'd1;
          end
        end else begin
          adv_cyc = cyc_reg + 25'd1;
        end
      end
      GAP: begin
        if (cyc_reg == GAP_TIME) begin
          adv_cyc = 25'd0;
          if (idx_reg != 4'd15) begin
            adv_state = NOTE;
            adv_idx   = idx_reg + 4'd1;
          end else if (loop_en) begin
            adv_state = NOTE;
            adv_idx   = 4'd0;
          end else begin
            adv_state = IDLE;
            adv_idx   = 4'd0;
            adv_done  = 1'b1;
          end
        end else begin
          adv_cyc = cyc_reg + 25'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    resume_next = resume_reg;
    idx_next    = idx_reg;
    cyc_next    = cyc_reg;
    beat_next   = beat_reg;
    done_next   = 1'b0;
    if (key_stop) begin
      state_next = IDLE;
      idx_next   = 4'd0;
      cyc_next   = 25'd0;
      beat_next  = 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (key_play) begin
            state_next = NOTE;
            idx_next   = 4'd0;
            cyc_next   = 25'd0;
            beat_next  = 2'd0;
          end
        end
        NOTE, GAP: begin
          // The cycle in which key_play arrives was already played, so the
          // counters still advance; the pause freezes the advanced position.
          state_next = adv_state;
          idx_next   = adv_idx;
          cyc_next   = adv_cyc;
          beat_next  = adv_beat;
          done_next  = adv_done;
          if (key_play && adv_state != IDLE) begin
            state_next  = PAUSE;
            resume_next = adv_state;
          end
        end
        PAUSE: begin
          if (key_play) state_next = resume_reg;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign code_next = song_code(idx_next);
  assign freq_next = divider(code_next);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      resume_reg   <= IDLE;
      idx_reg      <= 4'd0;
      cyc_reg      <= 25'd0;
      beat_reg     <= 2'd0;
      freq_cnt_max <= 18'd0;
      beep_en      <= 1'b0;
      note_idx     <= 4'd0;
      playing      <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      resume_reg <= resume_next;
      idx_reg    <= idx_next;
      cyc_reg    <= cyc_next;
      beat_reg   <= beat_next;
      note_idx   <= idx_next;
      playing    <= (state_next == NOTE) || (state_next == GAP);
      song_done  <= done_next;
      // Only a sounding (non-rest) NOTE drives the tone stage.
      if (state_next == NOTE && code_next != 3'd0) begin
        freq_cnt_max <= freq_next;
        beep_en      <= 1'b1;
      end else begin
        freq_cnt_max <= 18'd0;
        beep_en      <= 1'b0;
      end
    end
  end

endmodule
